rf_access_master: RTL and testbench
===================================

// Module: rf_access_master
// PURPOSE
//  Initiator for the generated register-file software interface. Takes single
//  read/write requests on a valid/ready stream and drives the RF's
//  address/read_en/write_en/write_data port. Waits for access_complete or
//  invalid_address, then returns read data and a status on a response stream.
//  Sits between a host bridge and any generated RF (e.g. RAM-backed RFs).
// PARAMETERS
//  ADDR_WIDTH  5    RF word address width (drives address[7:3] of a 64-bit RF)
//  DATA_WIDTH  64   RF data width
//  TIMEOUT     255  max cycles spent waiting for completion, 1..255
// PORTS
//  clk                 in   1           clock
//  res                 in   1           synchronous reset, active high
//  req_valid           in   1           request present
//  req_ready           out  1           request accepted when valid&ready
//  req_write           in   1           1 = write, 0 = read
//  req_addr            in   ADDR_WIDTH  RF word address
//  req_wdata           in   DATA_WIDTH  write data
//  rsp_valid           out  1           response present
//  rsp_ready           in   1           response consumed when valid&ready
//  rsp_rdata           out  DATA_WIDTH  read data (0 for writes and errors)
//  rsp_status          out  2           00 ok, 01 invalid address, 10 timeout
//  err_count           out  8           saturating count of non-ok responses
//  rf_address          out  ADDR_WIDTH  to RF address
//  rf_read_en          out  1           to RF read_en
//  rf_write_en         out  1           to RF write_en
//  rf_write_data       out  DATA_WIDTH  to RF write_data
//  rf_read_data        in   DATA_WIDTH  from RF read_data
//  rf_access_complete  in   1           from RF access_complete
//  rf_invalid_address  in   1           from RF invalid_address
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (res). All outputs
//    are registered.
//  - Reset values: all outputs 0. FSM goes to IDLE. Any in-flight transaction
//    is dropped and produces no response. Reset has priority over all other
//    events in every state.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. One transaction outstanding.
//  - IDLE: req_ready=1. On valid&ready, register addr/wdata/write into
//    rf_address/rf_write_data/op. Go to ISSUE.
//  - ISSUE (1 cycle): exactly one of rf_read_en/rf_write_en is high.
//    Go to WAIT.
//  - rf_address and rf_write_data hold stable from ISSUE until RESP exits.
//    Enables are single-cycle pulses and are never re-asserted for the same
//    request.
//  - Completion may be sampled in ISSUE or WAIT. A completion is
//    rf_access_complete=1 or rf_invalid_address=1.
//    * invalid_address=1: status 01, rdata 0. Invalid has priority when both
//      inputs are high in the same cycle.
//    * else if read: rdata=rf_read_data, captured in the completion cycle,
//      status 00.
//    * else (write): rdata 0, status 00.
//  - Timeout: an 8-bit counter clears in ISSUE and increments every WAIT
//    cycle. At count==TIMEOUT with no completion: status 10, rdata 0, go to
//    RESP. A completion arriving later is ignored.
//  - RESP: rsp_valid=1, with rdata/status held stable until rsp_ready. On
//    valid&ready go to IDLE; req_ready rises the next cycle. No bypass: at
//    least 4 cycles from request accept to the next accept.
//  - err_count increments by 1 on each non-ok response entering RESP and
//    saturates at 255.
//  - rf_access_complete/rf_invalid_address seen in IDLE or RESP are ignored.
// TESTING
//  1 reset: hold res 3 cycles mid-WAIT -> all outputs 0, no rsp_valid,
//    req_ready=1 one cycle after release.
//  2 write addr 5 data 0x5 -> one rf_write_en pulse with rf_address=5;
//    complete -> rsp status 00, rdata 0.
//  3 write i to addr i for i=0..31, then read all -> every rsp_rdata==i,
//    status 00, err_count 0.
//  4 read with rf_invalid_address=1 and rf_access_complete=1 in the same
//    cycle -> status 01, rdata 0, err_count +1.
//  5 read, RF never completes, TIMEOUT=8 -> status 10 after 8 WAIT cycles;
//    a late complete is ignored.
//  6 rsp_ready held low for 10 cycles -> rsp fields stable, req_ready=0,
//    no new rf enable pulse.

Source files
------------

// File: rtl/rf_access_master.sv
// Single-outstanding initiator for a generated register file: accepts one
// read/write request, pulses the RF enable, waits for completion or timeout.
module rf_access_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_status,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic                  rf_read_en,
    output logic                  rf_write_en,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    input  logic                  rf_access_complete,
    input  logic                  rf_invalid_address
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // The timer is compared against TIMEOUT-1 because the comparison happens
    // before the increment: the Nth WAIT cycle is the last one waited.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t          state_reg;
    logic            op_write_reg;
    logic [7:0]      timer_reg;

    logic            done;
    logic            done_hit;
    logic            timeout_hit;
    logic            err_hit;
    logic [1:0]      status_next;
    logic [DATA_WIDTH-1:0] rdata_next;

    always_comb begin
        done        = rf_access_complete | rf_invalid_address;
        done_hit    = ((state_reg == S_ISSUE) || (state_reg == S_WAIT)) && done;
        timeout_hit = (state_reg == S_WAIT) && !done && (timer_reg == TIMEOUT_LAST);
        err_hit     = timeout_hit | (done_hit & rf_invalid_address);
        status_next = 2'b00;
        rdata_next  = '0;
        if (timeout_hit) begin
            status_next = 2'b10;
        end else if (rf_invalid_address) begin
            status_next = 2'b01;
        end else if (!op_write_reg) begin
            rdata_next  = rf_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_reg     <= S_IDLE;
            op_write_reg  <= 1'b0;
            timer_reg     <= '0;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_status    <= 2'b00;
            err_count     <= '0;
            rf_address    <= '0;
            rf_read_en    <= 1'b0;
            rf_write_en   <= 1'b0;
            rf_write_data <= '0;
        end else begin
            rf_read_en  <= 1'b0;
            rf_write_en <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req_ready && req_valid) begin
                        req_ready     <= 1'b0;
                        rf_address    <= req_addr;
                        rf_write_data <= req_wdata;
                        op_write_reg  <= req_write;
                        rf_write_en   <= req_write;
                        rf_read_en    <= !req_write;
                        state_reg     <= S_ISSUE;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    timer_reg <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    timer_reg <= timer_reg + 8'd1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // Completion or timeout overrides the ISSUE/WAIT transitions above.
            if (done_hit || timeout_hit) begin
                state_reg  <= S_RESP;
                rsp_valid  <= 1'b1;
                rsp_status <= status_next;
                rsp_rdata  <= rdata_next;
                if (err_hit && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_access_master.sv
// Randomized bench for rf_access_master: an RF responder with programmable
// latency/error behaviour plus a transaction-level reference model.
module tb_rf_access_master;

    localparam int AW  = 5;
    localparam int DW  = 64;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_status;
    logic [7:0]    err_count;
    logic [AW-1:0] rf_address;
    logic          rf_read_en;
    logic          rf_write_en;
    logic [DW-1:0] rf_write_data;
    logic [DW-1:0] rf_read_data = '0;
    logic          rf_access_complete = 1'b0;
    logic          rf_invalid_address = 1'b0;

    always #5 clk = ~clk;

    rf_access_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .err_count(err_count),
        .rf_address(rf_address), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
        .rf_access_complete(rf_access_complete), .rf_invalid_address(rf_invalid_address)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // RF responder: mode 0 normal, 1 invalid+complete together, 2 never completes.
    // Completion comes rf_lat cycles after the enable pulse (0 = same cycle).
    logic [DW-1:0] rf_mem [0:31];
    int            rf_mode = 0;
    int            rf_lat  = 0;
    int            cd      = -1;
    int            en_pulses = 0;
    int            both_en   = 0;
    logic [AW-1:0] pulse_addr = '0;

    always @(negedge clk) begin
        rf_access_complete = 1'b0;
        rf_invalid_address = 1'b0;
        rf_read_data = {$urandom, $urandom};
        if (rf_read_en || rf_write_en) begin
            en_pulses++;
            pulse_addr = rf_address;
            if (rf_read_en && rf_write_en) both_en++;
            if (rf_write_en && rf_mode != 1) rf_mem[rf_address] = rf_write_data;
            cd = (rf_mode == 2) ? -1 : rf_lat;
        end else if (cd > 0) begin
            cd--;
        end
        if (cd == 0) begin
            cd = -1;
            rf_access_complete = 1'b1;
            if (rf_mode == 1) rf_invalid_address = 1'b1;
            else rf_read_data = rf_mem[rf_address];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:31];
    int            ref_err = 0;

    task automatic wait_ready(input string tag);
        int budget = 0;
        @(negedge clk);
        while (!(req_ready && cd == -1) && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 60) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int mode, input int lat, input int hold);
        bit            tmo;
        logic [1:0]    exp_status;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
        int            cycles;
        int            p0;
        logic [DW-1:0] h_rdata;
        logic [1:0]    h_status;

        tmo        = (mode == 2) || (lat > TMO);
        exp_status = tmo ? 2'b10 : ((mode == 1) ? 2'b01 : 2'b00);
        exp_rdata  = (exp_status == 2'b00 && !wr) ? ref_mem[a] : '0;
        if (wr && mode != 1) ref_mem[a] = d;
        exp_lat    = tmo ? TMO + 2 : lat + 2;
        if (exp_status != 2'b00 && ref_err < 255) ref_err++;

        wait_ready("txn");
        rf_mode = mode;
        rf_lat  = lat;
        p0      = en_pulses;
        req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = {$urandom, $urandom};
        req_addr  = AW'($urandom);
        check("ready_low_after_accept", req_ready, 0);

        cycles = 0;
        while (!rsp_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("latency", cycles, exp_lat);
        check("enable_pulses", en_pulses - p0, 1);
        check("pulse_addr", pulse_addr, a);
        check("both_enables", both_en, 0);

        h_rdata  = rsp_rdata;
        h_status = rsp_status;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, h_rdata);
            check("hold_status", rsp_status, h_status);
            check("hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        if (hold > 0) check("hold_no_pulse", en_pulses - p0, 1);

        check("rsp_status", rsp_status, exp_status);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("err_count", err_count, ref_err);

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("no_bypass_ready", req_ready, 0);
        $display("txn %0d wr=%0d addr=%0d mode=%0d lat=%0d status=%0d rdata=%h err=%0d cycles=%0d",
                 n_txn, wr, a, mode, lat, rsp_status, rsp_rdata, err_count, cycles);
        n_txn++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {req_ready, rsp_valid, rf_read_en, rf_write_en, rsp_status, err_count}, 0);
        check({tag, "_rdata"}, rsp_rdata, 0);
        check({tag, "_wdata"}, rf_write_data, 0);
        check({tag, "_addr"}, rf_address, 0);
    endtask

    initial begin
        int seen;
        int p0;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i]  = '0;
            ref_mem[i] = '0;
        end

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("por");
        res = 1'b0;
        @(negedge clk);
        check("por_ready", req_ready, 1);

        // Single write
        do_txn(1'b1, 5'd5, 64'h5, 0, 1, 0);

        // Fill then read back every address
        for (int i = 0; i < 32; i++) do_txn(1'b1, AW'(i), DW'(i), 0, $urandom_range(0, 3), 0);
        for (int i = 0; i < 32; i++) do_txn(1'b0, AW'(i), '0, 0, $urandom_range(0, 3), 0);
        check("err_after_fill", err_count, 0);

        // Invalid and complete together
        do_txn(1'b0, 5'd3, '0, 1, 2, 0);

        // Completion on the last permitted WAIT cycle, then one cycle too late
        do_txn(1'b0, 5'd7, '0, 0, TMO, 0);
        do_txn(1'b0, 5'd7, '0, 0, TMO + 1, 0);
        // Never completes, then a very late completion must be ignored
        do_txn(1'b0, 5'd9, '0, 2, 0, 0);
        do_txn(1'b1, 5'd10, 64'hDEAD_BEEF_0000_0010, 0, 15, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("late_complete_ignored", seen, 0);

        // Response back-pressure
        do_txn(1'b0, 5'd4, '0, 0, 1, 10);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            int m;
            m = $urandom_range(0, 9);
            m = (m < 7) ? 0 : ((m < 9) ? 1 : 2);
            do_txn(1'($urandom), AW'($urandom), {$urandom, $urandom}, m,
                   $urandom_range(0, 10), $urandom_range(0, 2));
        end

        // Saturate the error counter
        for (int i = 0; i < 256; i++) do_txn(1'b0, AW'(i), '0, 1, 0, 0);
        check("err_saturated", err_count, 255);

        // Reset in the middle of WAIT drops the transaction
        wait_ready("rst");
        rf_mode = 2;
        p0 = en_pulses;
        req_write = 1'b1; req_addr = 5'd21; req_wdata = 64'hA5A5; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        res = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_reset");
        res = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = rf_mem[i];
        ref_err = 0;
        @(negedge clk);
        check("post_reset_ready", req_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("post_reset_no_rsp", seen, 0);
        check("post_reset_pulses", en_pulses - p0, 1);

        do_txn(1'b0, 5'd5, '0, 0, 2, 0);
        do_txn(1'b0, 5'd12, '0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
